// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: decode inputs from the datapath, strobes and PC back to it.
interface multicycle_control_unit_if;
    logic [5:0]  opcode;
    logic [2:0]  flags;
    logic [31:0] branch_target;
    logic [31:0] alu_result;
    logic [31:0] PCout;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        DataPCSel;
    logic        RegSelect;
    logic [2:0]  ALUop;
    logic [1:0]  ALUinSel;
    logic        halted;
    logic        illegal;
    logic [31:0] instr_count;

    modport master (
        input  opcode, flags, branch_target, alu_result,
        output PCout, RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect,
               ALUop, ALUinSel, halted, illegal, instr_count
    );

    modport slave (
        output opcode, flags, branch_target, alu_result,
        input  PCout, RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect,
               ALUop, ALUinSel, halted, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with latched branch flags, PC, retire counter and HALT.
module multicycle_control_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_unit_if.master   bus
);
    localparam logic [5:0] OP_ALUR = 6'b000000;
    localparam logic [5:0] OP_ALUI = 6'b000001;
    localparam logic [5:0] OP_LD   = 6'b000010;
    localparam logic [5:0] OP_ST   = 6'b000011;
    localparam logic [5:0] OP_BR   = 6'b000100;
    localparam logic [5:0] OP_BZ   = 6'b000101;
    localparam logic [5:0] OP_BN   = 6'b000110;
    localparam logic [5:0] OP_BC   = 6'b000111;
    localparam logic [5:0] OP_CALL = 6'b001000;
    localparam logic [5:0] OP_JR   = 6'b001001;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [1:0] {P_FETCH, P_MEM, P_WB, P_HALT} path_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] alu_in_sel;
        logic       mem_to_reg;
        logic       data_pc_sel;
        logic       reg_select;
    } dec_t;

    state_t      state_q, state_d;
    dec_t        dec_c, dec_q, dec_d;
    path_t       path_c;
    logic        illegal_c, is_ld_c, is_st_c, is_jr_c, taken_c, alu_c;
    logic [31:0] pc_q, pc_d, cnt_q, cnt_d, pc_inc;
    logic [2:0]  flag_q, flag_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        halted_q, halted_d;

    assign pc_inc = pc_q + 32'd1;

    // Opcode decode; only meaningful while in EXEC. Branches test the latched flags.
    always_comb begin
        dec_c     = '0;
        path_c    = P_FETCH;
        illegal_c = 1'b0;
        is_ld_c   = 1'b0;
        is_st_c   = 1'b0;
        is_jr_c   = 1'b0;
        taken_c   = 1'b0;
        alu_c     = 1'b0;
        if (bus.opcode == HALT_OPCODE) begin
            path_c = P_HALT;
        end else begin
            case (bus.opcode)
                OP_ALUR: begin
                    dec_c.mem_to_reg = 1'b1;
                    path_c           = P_WB;
                    alu_c            = 1'b1;
                end
                OP_ALUI: begin
                    dec_c.alu_op     = 3'b001;
                    dec_c.alu_in_sel = 2'b10;
                    dec_c.mem_to_reg = 1'b1;
                    path_c           = P_WB;
                    alu_c            = 1'b1;
                end
                OP_LD: begin
                    dec_c.alu_op     = 3'b010;
                    dec_c.alu_in_sel = 2'b10;
                    path_c           = P_MEM;
                    is_ld_c          = 1'b1;
                end
                OP_ST: begin
                    dec_c.alu_op     = 3'b010;
                    dec_c.alu_in_sel = 2'b10;
                    path_c           = P_MEM;
                    is_st_c          = 1'b1;
                end
                OP_BR:   taken_c = 1'b1;
                OP_BZ:   taken_c = flag_q[0];
                OP_BN:   taken_c = flag_q[1];
                OP_BC:   taken_c = flag_q[2];
                OP_CALL: begin
                    dec_c.alu_op      = 3'b011;
                    dec_c.alu_in_sel  = 2'b01;
                    dec_c.data_pc_sel = 1'b1;
                    dec_c.reg_select  = 1'b1;
                    path_c            = P_WB;
                end
                OP_JR: begin
                    dec_c.alu_op     = 3'b100;
                    dec_c.alu_in_sel = 2'b01;
                    is_jr_c          = 1'b1;
                end
                default: illegal_c = 1'b1;
            endcase
        end
    end

    // Next state; strobes are computed for the state being entered so they register cleanly.
    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        halted_d    = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                dec_d = dec_c;
                if (alu_c) flag_d = bus.flags;
                case (path_c)
                    P_WB: begin
                        state_d     = S_WB;
                        reg_write_d = 1'b1;
                    end
                    P_MEM: begin
                        state_d     = S_MEM;
                        mem_read_d  = is_ld_c;
                        mem_write_d = is_st_c;
                    end
                    P_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        dec_d    = '0;
                    end
                    default: begin
                        state_d = S_FETCH;
                        dec_d   = '0;
                        cnt_d   = cnt_q + 32'd1;
                        if (is_jr_c)      pc_d = bus.alu_result;
                        else if (taken_c) pc_d = bus.branch_target;
                        else              pc_d = pc_inc;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_read_q) begin
                    state_d     = S_WB;
                    reg_write_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    dec_d   = '0;
                    cnt_d   = cnt_q + 32'd1;
                    pc_d    = pc_inc;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                dec_d   = '0;
                cnt_d   = cnt_q + 32'd1;
                pc_d    = dec_q.data_pc_sel ? bus.branch_target : pc_inc;
            end
            S_HALT: halted_d = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            dec_q       <= '0;
            pc_q        <= RESET_PC;
            cnt_q       <= 32'd0;
            flag_q      <= 3'd0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            halted_q    <= halted_d;
        end
    end

    // Decode fields come straight from the opcode in EXEC, then hold from the latched copy.
    assign bus.ALUop       = (state_q == S_EXEC) ? dec_c.alu_op      : dec_q.alu_op;
    assign bus.ALUinSel    = (state_q == S_EXEC) ? dec_c.alu_in_sel  : dec_q.alu_in_sel;
    assign bus.MemtoReg    = (state_q == S_EXEC) ? dec_c.mem_to_reg  : dec_q.mem_to_reg;
    assign bus.DataPCSel   = (state_q == S_EXEC) ? dec_c.data_pc_sel : dec_q.data_pc_sel;
    assign bus.RegSelect   = (state_q == S_EXEC) ? dec_c.reg_select  : dec_q.reg_select;
    assign bus.illegal     = (state_q == S_EXEC) && illegal_c;
    assign bus.RegWrite    = reg_write_q;
    assign bus.MemRead     = mem_read_q;
    assign bus.MemWrite    = mem_write_q;
    assign bus.halted      = halted_q;
    assign bus.PCout       = pc_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: an instruction-level model queues per-cycle expectations, compared each negedge.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if dp();

    multicycle_control_unit #(
        .RESET_PC   (32'h0000_0000),
        .HALT_OPCODE(6'b111111)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dp)
    );

    typedef struct packed {
        logic [12:0] ctl;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [2:0]  m_flag;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, ALUop, ALUinSel, halted, illegal}
    function automatic logic [12:0] pack_ctl(input logic rw, input logic mr, input logic mw,
                                             input logic mtr, input logic dps, input logic rs,
                                             input logic [2:0] aop, input logic [1:0] ins,
                                             input logic h, input logic il);
        return {rw, mr, mw, mtr, dps, rs, aop, ins, h, il};
    endfunction

    function automatic exp_t mk(input logic [12:0] c, input logic [31:0] p, input logic [31:0] n);
        exp_t e;
        e.ctl = c;
        e.pc  = p;
        e.cnt = n;
        return e;
    endfunction

    task automatic model_instr(input logic [5:0] op, input logic [2:0] fl,
                               input logic [31:0] tgt, input logic [31:0] alu, input int n_halt);
        logic [2:0] aop = 3'b000;
        logic [1:0] ins = 2'b00;
        logic mtr = 1'b0, dps = 1'b0, rs = 1'b0, il = 1'b0;
        logic taken = 1'b0, jr = 1'b0, ld = 1'b0, upd = 1'b0;
        int   path = 0; // 0 retire, 1 mem, 2 wb, 3 halt
        if (op == 6'b111111) path = 3;
        else begin
            case (op)
                6'd0: begin mtr = 1; path = 2; upd = 1; end
                6'd1: begin aop = 3'b001; ins = 2'b10; mtr = 1; path = 2; upd = 1; end
                6'd2: begin aop = 3'b010; ins = 2'b10; path = 1; ld = 1; end
                6'd3: begin aop = 3'b010; ins = 2'b10; path = 1; end
                6'd4: taken = 1;
                6'd5: taken = m_flag[0];
                6'd6: taken = m_flag[1];
                6'd7: taken = m_flag[2];
                6'd8: begin aop = 3'b011; ins = 2'b01; dps = 1; rs = 1; path = 2; taken = 1; end
                6'd9: begin aop = 3'b100; ins = 2'b01; jr = 1; end
                default: il = 1;
            endcase
        end
        sb.push_back(mk(13'd0, m_pc, m_cnt));
        sb.push_back(mk(pack_ctl(0, 0, 0, mtr, dps, rs, aop, ins, 0, il), m_pc, m_cnt));
        if (upd) m_flag = fl;
        if (path == 1) begin
            sb.push_back(mk(pack_ctl(0, ld, !ld, mtr, dps, rs, aop, ins, 0, 0), m_pc, m_cnt));
            if (ld) sb.push_back(mk(pack_ctl(1, 0, 0, mtr, dps, rs, aop, ins, 0, 0), m_pc, m_cnt));
        end else if (path == 2) begin
            sb.push_back(mk(pack_ctl(1, 0, 0, mtr, dps, rs, aop, ins, 0, 0), m_pc, m_cnt));
        end
        if (path == 3) begin
            for (int i = 0; i < n_halt; i++)
                sb.push_back(mk(pack_ctl(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 1, 0), m_pc, m_cnt));
        end else begin
            m_pc  = jr ? alu : (taken ? tgt : m_pc + 32'd1);
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    // Called at the start of a FETCH cycle; stop>0 checks only that many cycles and
    // raises reset before the edge that would end the last one.
    task automatic run(input string tag, input logic [5:0] op, input logic [2:0] fl,
                       input logic [31:0] tgt, input logic [31:0] alu,
                       input int n_halt = 0, input int stop = 0);
        int   n;
        exp_t e;
        logic [12:0] obs;
        dp.opcode        = op;
        dp.flags         = fl;
        dp.branch_target = tgt;
        dp.alu_result    = alu;
        model_instr(op, fl, tgt, alu, n_halt);
        n = (stop != 0) ? stop : sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e   = sb.pop_front();
            obs = {dp.RegWrite, dp.MemRead, dp.MemWrite, dp.MemtoReg, dp.DataPCSel,
                   dp.RegSelect, dp.ALUop, dp.ALUinSel, dp.halted, dp.illegal};
            check_val({tag, ".ctl"}, 32'(obs), 32'(e.ctl));
            check_val({tag, ".pc"}, dp.PCout, e.pc);
            check_val({tag, ".cnt"}, dp.instr_count, e.cnt);
            if (stop != 0 && i == n - 1) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        if (stop != 0) sb.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_pc   = 32'h0000_0000;
        m_cnt  = 32'd0;
        m_flag = 3'b000;
    endtask

    initial begin
        dp.opcode        = 6'd0;
        dp.flags         = 3'd0;
        dp.branch_target = 32'd0;
        dp.alu_result    = 32'd0;
        do_reset();
        run("alur0",  6'd0, 3'b000, 32'h0,  32'h0);
        run("alui1",  6'd1, 3'b000, 32'h0,  32'h0);
        run("alui2",  6'd1, 3'b000, 32'h0,  32'h0);
        run("br5",    6'd4, 3'b111, 32'h5,  32'h0);
        run("ld5",    6'd2, 3'b000, 32'h9,  32'h0);
        run("st6",    6'd3, 3'b000, 32'h9,  32'h0);
        run("alu_z",  6'd0, 3'b001, 32'h0,  32'h0);
        run("st_nf",  6'd3, 3'b000, 32'h0,  32'h0);
        run("bz_tk",  6'd5, 3'b000, 32'h40, 32'h0);
        run("alu_nz", 6'd0, 3'b000, 32'h0,  32'h0);
        run("bz_nt",  6'd5, 3'b001, 32'h80, 32'h0);
        run("alu_sc", 6'd1, 3'b110, 32'h0,  32'h0);
        run("bn_tk",  6'd6, 3'b000, 32'h50, 32'h0);
        run("bc_tk",  6'd7, 3'b000, 32'h60, 32'h0);
        run("bz_nt2", 6'd5, 3'b001, 32'h70, 32'h0);
        run("jr10",   6'd9, 3'b000, 32'h0,  32'd10);
        run("call",   6'd8, 3'b000, 32'h20, 32'h0);
        run("jr11",   6'd9, 3'b000, 32'h0,  32'd11);
        run("illeg",  6'b010101, 3'b000, 32'h0, 32'h0);
        run("halt",   6'b111111, 3'b000, 32'h0, 32'h0, 20);
        do_reset();
        run("post_rst", 6'd0, 3'b000, 32'h0, 32'h0);
        run("ld_rst",   6'd2, 3'b000, 32'h0, 32'h0, 0, 4);
        do_reset();
        run("after_rst", 6'd9, 3'b000, 32'h0, 32'hFFFF_FFFF);
        run("wrap",      6'd0, 3'b000, 32'h0, 32'h0);
        run("final",     6'd1, 3'b000, 32'h0, 32'h0);
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control end of the arithmetic/memory datapath interface: consumes the datapath's `opcode`, `flags`, `address` (zero-extended immediate) and `ALUresult`.
- Drives every datapath control strobe plus the program counter fed to the datapath's `PCin`.
- Implements a multi-cycle FETCH/EXEC/MEM/WB sequencer, a latched condition-flag register for branches, and HALT handling.

Parameters:
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode that freezes the sequencer.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- opcode  input  6  instruction[31:26] from datapath.
- flags  input  3  ALU flags {carry[2], sign[1], zero[0]}, combinational from datapath.
- branch_target  input  32  datapath `address` (zero-extended imm16).
- alu_result  input  32  datapath `ALUresult` (jump-register target).
- PCout  output  32  program counter to datapath PCin.
- RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect  output  1 each  datapath controls.
- ALUop  output  3  ALU operation class.
- ALUinSel  output  2  ALU B-input select (00 reg, 01 zero, 10 imm, 11 one).
- halted  output  1  high in HALT state.
- illegal  output  1  one-cycle pulse on undefined opcode.
- instr_count  output  32  retired-instruction counter.

Behaviour:
- Reset (sync, high): state=FETCH, PCout=RESET_PC, flag_reg=0, instr_count=0, halted=0, illegal=0, all control outputs 0. Reset dominates everything, including HALT and mid-instruction states; an in-flight RegWrite/MemWrite is dropped.
- States: FETCH -> EXEC -> {MEM, WB, FETCH}; MEM -> {WB, FETCH}; WB -> FETCH; HALT is absorbing.
- FETCH (1 cycle): all strobes 0; instruction memory captures PCout; opcode is valid from next state onward.
- EXEC: decode opcode; drive ALUop/ALUinSel/MemtoReg/DataPCSel/RegSelect. These hold unchanged through MEM/WB of the same instruction and clear to 0 in FETCH.
- Opcode table (ALUop, ALUinSel, path):
  - 000000 ALU-reg (000, 00): EXEC->WB, MemtoReg=1.
  - 000001 ALU-imm (001, 10): EXEC->WB, MemtoReg=1.
  - 000010 LD (010, 10): EXEC->MEM->WB, MemtoReg=0.
  - 000011 ST (010, 10): EXEC->MEM->FETCH.
  - 000100 BR: EXEC->FETCH.
  - 000101 BZ / 000110 BN / 000111 BC: EXEC->FETCH; test flag_reg[0] / [1] / [2] respectively.
  - 001000 CALL (011, 01): EXEC->WB, RegSelect=1, DataPCSel=1 (writes PC+1 to r31).
  - 001001 JR (100, 01): EXEC->FETCH.
  - HALT_OPCODE: EXEC->HALT.
- MEM: MemRead=1 (LD) or MemWrite=1 (ST) for exactly one cycle.
- WB: RegWrite=1 for exactly one cycle; never asserted in any other state.
- flag_reg <= flags at end of EXEC only for opcodes 000000/000001. Branches use flag_reg (flags from the most recent ALU instruction), never live flags.
- PC update on the last cycle of each instruction:
  - Taken BR/Bcc and CALL: PC <= branch_target.
  - JR: PC <= alu_result.
  - Otherwise: PC <= PC+1 (32-bit wrap, 0xFFFFFFFF -> 0).
- instr_count increments by 1 in that same cycle, with 32-bit wrap.
- Latency: ALU/CALL = 3 cycles; LD = 4; ST = 3; branches/JR = 2.
- Undefined opcode: executes as NOP (EXEC->FETCH, PC+1, counted); illegal=1 during that EXEC cycle only.
- HALT: halted=1, PC frozen, all strobes 0, instr_count not incremented for HALT; exit only via reset.

Test Plan:
- Reset then ALU-reg at PC 0: RegWrite high exactly in cycle 3 and never elsewhere, PCout=1, instr_count=1.
- LD at PC 5: MemRead high one cycle (MEM), then RegWrite with MemtoReg=0, PCout=6 after 4 cycles. ST at PC 6: MemWrite one cycle, no RegWrite, PCout=7 after 3 cycles.
- ALU result zero (flags=3'b001), then BZ with branch_target=0x40: PCout=0x40. Repeat with flags=3'b000 at EXEC: PCout=PC+1. An intervening ST with flags=3'b000 must not alter flag_reg.
- CALL at PC 10, target 0x20: RegSelect=1, DataPCSel=1, RegWrite one cycle, PCout=0x20. Then JR with alu_result=11: PCout=11.
- Opcode 6'b010101: illegal pulses one cycle, PC+1. Then HALT: halted=1, PCout stable for 20 cycles; reset: PCout=RESET_PC, halted=0.
- Assert reset during WB of an LD: RegWrite=0 in the following cycle, state FETCH, PCout=0; also PCout=0xFFFFFFFF plus ALU op wraps to 0.
